// File: rtl/split_serializer_if.sv
// Handshake bundle between a wide-word producer and the narrow-slice consumer
// of split_serializer; widths follow the same parameters as the block.
interface split_serializer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8
);
  localparam int N     = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = ($clog2(N) > 1) ? $clog2(N) : 1;

  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_msb_first;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_msb_first, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_last, out_valid
  );

  modport slave (
    input  in_data, in_msb_first, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_last, out_valid
  );
endinterface

// File: rtl/split_serializer.sv
// Splits one IN_WIDTH word into IN_WIDTH/OUT_WIDTH slices, emitted one per
// transfer in the byte order captured with the word.
module split_serializer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  split_serializer_if.slave  bus
);
  localparam int N     = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(N - 1);

  if (((IN_WIDTH % OUT_WIDTH) != 0) || (N < 2)) begin : g_bad_params
    $error("split_serializer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     beat_q, beat_d;
  logic [IN_WIDTH-1:0]  hold_q, hold_d;
  logic                 order_q, order_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]     out_idx_q, out_idx_d;
  logic                 out_last_q, out_last_d;

  logic                 xfer_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic [IDX_W-1:0]     k_s;

  // in_ready looks only at registered state and out_ready, never at in_valid
  always_comb begin
    xfer_s = out_valid_q && bus.out_ready;
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = (state_q == ST_IDLE) || (xfer_s && out_last_q);
    end
    accept_s = bus.in_valid && in_ready_s;
  end

  // Next word/beat bookkeeping: an accept always restarts at beat 0
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    order_d = order_q;
    if (accept_s) begin
      state_d = ST_SEND;
      beat_d  = {IDX_W{1'b0}};
      hold_d  = bus.in_data;
      order_d = bus.in_msb_first;
    end else if (xfer_s) begin
      if (beat_q == LAST_BEAT) begin
        state_d = ST_IDLE;
        beat_d  = {IDX_W{1'b0}};
      end else begin
        beat_d  = beat_q + IDX_W'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // Slice outputs are precomputed from next state so they leave straight from flops
  always_comb begin
    k_s = order_d ? (LAST_BEAT - beat_d) : beat_d;
    if (state_d == ST_SEND) begin
      out_valid_d = 1'b1;
      out_idx_d   = k_s;
      out_data_d  = OUT_WIDTH'(hold_d >> (k_s * OUT_WIDTH));
      out_last_d  = (beat_d == LAST_BEAT);
    end else begin
      out_valid_d = 1'b0;
      out_idx_d   = {IDX_W{1'b0}};
      out_data_d  = {OUT_WIDTH{1'b0}};
      out_last_d  = 1'b0;
    end
  end

  // State and output registers; reset discards any word in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= {IDX_W{1'b0}};
      hold_q      <= {IN_WIDTH{1'b0}};
      order_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_WIDTH{1'b0}};
      out_idx_q   <= {IDX_W{1'b0}};
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      hold_q      <= hold_d;
      order_q     <= order_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
endmodule
